// File: rtl/bcd_display_ctrl.sv
// 16-bit binary to 4-digit BCD converter (shift/add-3, one bit per clock) with a
// multiplexed active-low seven-segment scan driver showing the last committed result.
module bcd_display_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] VALUE,
   input  logic        LOAD,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] DIGITS,
   output logic [6:0]  SEG,
   output logic [3:0]  AN
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t         state;
   logic [15:0]    shreg;
   logic [15:0]    acc;
   logic [3:0]     bitcnt;
   logic [15:0]    acc_adj;
   logic [15:0]    acc_next;

   logic [RW-1:0]  rcnt;
   logic [1:0]     sel;
   logic [3:0]     nibble;
   logic           lz;

   function automatic logic [15:0] add3(input logic [15:0] a);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Adjust then shift: the thousands carry-out falls off, giving VALUE mod 10000.
   always_comb begin
      acc_adj  = add3(acc);
      acc_next = {acc_adj[14:0], shreg[15]};
   end

   // A LOAD on the edge leaving COMMIT starts the next conversion directly,
   // so back-to-back requests complete every 17 cycles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         shreg  <= '0;
         acc    <= '0;
         bitcnt <= '0;
         DIGITS <= '0;
      end else begin
         case (state)
            IDLE, COMMIT: begin
               if (LOAD) begin
                  shreg  <= VALUE;
                  acc    <= '0;
                  bitcnt <= 4'd15;
                  state  <= SHIFT;
               end else begin
                  state  <= IDLE;
               end
            end
            SHIFT: begin
               acc    <= acc_next;
               shreg  <= {shreg[14:0], 1'b0};
               bitcnt <= bitcnt - 4'd1;
               if (bitcnt == 4'd0) begin
                  DIGITS <= acc_next;
                  state  <= COMMIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign BUSY = (state == SHIFT);
   assign DONE = (state == COMMIT);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rcnt <= '0;
         sel  <= '0;
      end else if (rcnt == REF_LAST) begin
         rcnt <= '0;
         sel  <= sel + 2'd1;
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      nibble = DIGITS[3:0];
      lz     = 1'b0;
      case (sel)
         2'd0: begin nibble = DIGITS[3:0];   lz = 1'b0;                     end
         2'd1: begin nibble = DIGITS[7:4];   lz = (DIGITS[15:4]  == 12'd0); end
         2'd2: begin nibble = DIGITS[11:8];  lz = (DIGITS[15:8]  == 8'd0);  end
         2'd3: begin nibble = DIGITS[15:12]; lz = (DIGITS[15:12] == 4'd0);  end
         default: begin nibble = DIGITS[3:0]; lz = 1'b0;                    end
      endcase
      AN  = (BLANK_LZ && lz) ? 4'b1111 : ~(4'b0001 << sel);
      SEG = seg_decode(nibble);
   end

endmodule
